// File: rtl/fixed_cossin_pair_seq_pkg.sv
// Shared sizes and FSM encoding for the cos/sin pair sequencer.
// The cos LUT uses the same constants, so both sides agree on sizes.
package fixed_cossin_pair_seq_pkg;

   localparam int FIXED_W    = 32;
   localparam int LUT_SIZE   = 360;
   localparam int SIN_OFFSET = 270;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE    = 3'd0;
   localparam state_t ST_REQ_SIN = 3'd1;
   localparam state_t ST_CAP_COS = 3'd2;
   localparam state_t ST_CAP_SIN = 3'd3;
   localparam state_t ST_HOLD    = 3'd4;

endpackage

// File: rtl/angle_mod360.sv
// Two-stage conditional-subtract reduction of a 0..1023 angle to 0..359.
// Used for input angles and for the +270 sin index wrap.
module angle_mod360
   import fixed_cossin_pair_seq_pkg::*;
(
   input  logic [9:0] angle,
   output logic [8:0] reduced
);

   logic [9:0] s1;
   logic [9:0] s2;

   // Two subtracts cover the whole 10-bit range (1023 - 720 = 303).
   always_comb begin
      s1 = angle;
      if (s1 >= 10'(LUT_SIZE))
         s1 = s1 - 10'(LUT_SIZE);
      s2 = s1;
      if (s2 >= 10'(LUT_SIZE))
         s2 = s2 - 10'(LUT_SIZE);
      reduced = 9'(s2);
   end

endmodule

// File: rtl/fixed_cossin_pair_seq.sv
// Sequences cos and sin reads from a single-port cos LUT and returns
// both values as one {cos, sin} result over valid/ready.
module fixed_cossin_pair_seq
   import fixed_cossin_pair_seq_pkg::*;
#(
   parameter int FW = FIXED_W,
   parameter int AW = 10
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [AW-1:0] in_angle,
   output logic [8:0]    lut_idx,
   input  logic [FW-1:0] lut_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [FW-1:0] out_cos,
   output logic [FW-1:0] out_sin,
   output logic [8:0]    out_angle
);

   state_t     state;
   logic [8:0] theta;
   logic [8:0] theta_in;
   logic [8:0] sin_idx;
   logic [9:0] angle_ext;
   logic [9:0] sin_sum;

   assign angle_ext = 10'(in_angle);
   assign sin_sum   = {1'b0, theta} + 10'(SIN_OFFSET);
   assign in_ready  = (state == ST_IDLE);
   assign out_angle = theta;

   angle_mod360 u_mod_in (
      .angle   (angle_ext),
      .reduced (theta_in)
   );

   angle_mod360 u_mod_sin (
      .angle   (sin_sum),
      .reduced (sin_idx)
   );

   // Walk one transaction: cos addr, sin addr, capture cos, capture sin,
   // then hold the result until the downstream takes it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         theta     <= '0;
         lut_idx   <= '0;
         out_cos   <= '0;
         out_sin   <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  theta   <= theta_in;
                  lut_idx <= theta_in;
                  state   <= ST_REQ_SIN;
               end
            end
            ST_REQ_SIN: begin
               lut_idx <= sin_idx;
               state   <= ST_CAP_COS;
            end
            ST_CAP_COS: begin
               out_cos <= lut_data;
               state   <= ST_CAP_SIN;
            end
            ST_CAP_SIN: begin
               out_sin   <= lut_data;
               out_valid <= 1'b1;
               state     <= ST_HOLD;
            end
            ST_HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fixed_cossin_pair_seq.sv
// Bench for the cos/sin pair sequencer: LUT model, directed cases,
// reset mid-flight and a random scoreboard run.
module tb_fixed_cossin_pair_seq;

   localparam int FW = 32;
   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [AW-1:0] in_angle;
   logic [8:0]    lut_idx;
   logic [FW-1:0] lut_data;
   logic          out_valid;
   logic          out_ready;
   logic [FW-1:0] out_cos;
   logic [FW-1:0] out_sin;
   logic [8:0]    out_angle;

   fixed_cossin_pair_seq #(.FW(FW), .AW(AW)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_angle  (in_angle),
      .lut_idx   (lut_idx),
      .lut_data  (lut_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_cos   (out_cos),
      .out_sin   (out_sin),
      .out_angle (out_angle)
   );

   always #5 clk = ~clk;

   logic [FW-1:0] lut [360];
   int n_err = 0;
   int n_chk = 0;
   int n_acc = 0;
   int n_out = 0;
   int cyc = 0;
   int acc_cyc = 0;
   int acc_prev = 0;
   int q_ang[$];

   logic          p_valid = 1'b0;
   logic          p_hs = 1'b0;
   logic [FW-1:0] p_cos;
   logic [FW-1:0] p_sin;
   logic [8:0]    p_ang;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Registered single-port LUT model, one clock of read latency.
   always @(posedge clk)
      lut_data <= lut[(lut_idx < 9'd360) ? lut_idx : 9'd0];

   always @(posedge clk)
      cyc <= cyc + 1;

   // Scoreboard: push accepted angles, pop and compare on handshakes,
   // and require stable outputs while a result waits.
   always @(negedge clk) begin
      if (reset) begin
         q_ang.delete();
         p_valid = 1'b0;
         p_hs = 1'b0;
      end else begin
         if (p_valid && !p_hs) begin
            check("hold_valid", out_valid, 1);
            check("hold_cos", out_cos, p_cos);
            check("hold_sin", out_sin, p_sin);
            check("hold_ang", out_angle, p_ang);
         end
         if (in_valid && in_ready) begin
            q_ang.push_back(int'(in_angle));
            n_acc++;
            acc_prev = acc_cyc;
            acc_cyc = cyc;
         end
         if (out_valid && out_ready) begin
            if (q_ang.size() == 0) begin
               check("spurious_out", 1, 0);
            end else begin
               int a, th;
               a = q_ang.pop_front();
               th = a % 360;
               check("sb_angle", out_angle, th);
               check("sb_cos", out_cos, lut[th]);
               check("sb_sin", out_sin, lut[(th + 270) % 360]);
            end
            n_out++;
         end
         p_valid = out_valid;
         p_hs = out_valid && out_ready;
         p_cos = out_cos;
         p_sin = out_sin;
         p_ang = out_angle;
      end
   end

   task automatic run_one(input int a);
      int th, si;
      th = a % 360;
      si = (th + 270) % 360;
      in_valid = 1'b1;
      in_angle = AW'(a);
      out_ready = 1'b1;
      @(negedge clk);
      check("acc_ready", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("idx_cos", lut_idx, th);
      @(posedge clk); #1;
      check("idx_sin", lut_idx, si);
      check("valid_e1", out_valid, 0);
      @(posedge clk); #1;
      check("valid_e2", out_valid, 0);
      @(posedge clk); #1;
      check("valid_lat", out_valid, 1);
      check("dir_angle", out_angle, th);
      check("dir_cos", out_cos, lut[th]);
      check("dir_sin", out_sin, lut[si]);
      @(posedge clk); #1;
      check("valid_drop", out_valid, 0);
      check("ready_back", in_ready, 1);
   endtask

   task automatic wait_acc(input int n, input string tag);
      int k = 0;
      while (n_acc < n && k < 50) begin
         @(posedge clk); #1;
         k++;
      end
      check(tag, n_acc >= n, 1);
   endtask

   initial begin
      int k;
      int target;
      for (int i = 0; i < 360; i++)
         lut[i] = $urandom;
      reset = 1'b1;
      in_valid = 1'b0;
      in_angle = '0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", out_valid, 0);
      check("rst_idx", lut_idx, 0);
      check("rst_cos", out_cos, 0);
      check("rst_sin", out_sin, 0);
      check("rst_angle", out_angle, 0);
      reset = 1'b0;
      @(posedge clk); #1;
      check("rst_ready", in_ready, 1);

      run_one(0);
      run_one(450);
      run_one(1023);
      run_one(359);
      run_one(720);

      // Back-to-back accepts with in_valid held.
      target = n_acc;
      in_valid = 1'b1;
      in_angle = 10'd10;
      out_ready = 1'b1;
      wait_acc(target + 1, "b2b_first");
      in_angle = 10'd20;
      wait_acc(target + 2, "b2b_second");
      check("b2b_period", acc_cyc - acc_prev, 5);
      in_valid = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      check("b2b_drained", q_ang.size(), 0);

      // Backpressure: result waits six clocks, new angle ignored.
      target = n_acc;
      in_valid = 1'b1;
      in_angle = 10'd123;
      out_ready = 1'b0;
      wait_acc(target + 1, "bp_acc");
      in_angle = 10'd77;
      k = 0;
      while (!out_valid && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      check("bp_valid_up", out_valid, 1);
      repeat (6) begin
         @(posedge clk); #1;
         check("bp_valid", out_valid, 1);
         check("bp_ready", in_ready, 0);
         check("bp_angle", out_angle, 123);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_release", out_valid, 0);
      check("bp_idle", in_ready, 1);
      check("bp_ignored", n_acc, target + 1);

      // Reset while in the cos-capture state.
      in_valid = 1'b1;
      in_angle = 10'd200;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_idx", lut_idx, 0);
      check("mid_rst_ready", in_ready, 1);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      check("post_rst_ready", in_ready, 1);
      check("post_rst_valid", out_valid, 0);
      run_one(45);

      // Random angles with random backpressure.
      target = n_acc + 1000;
      k = 0;
      while (n_acc < target && k < 40000) begin
         in_valid = ($urandom % 4) != 0;
         in_angle = AW'($urandom_range(0, 1023));
         out_ready = $urandom % 2;
         @(posedge clk); #1;
         k++;
      end
      check("rand_accepts", n_acc >= target, 1);
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      check("rand_drained", q_ang.size(), 0);
      check("rand_no_valid", out_valid, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
